ase_hssi_loopback_emul: RTL
===========================

// Module: ase_hssi_loopback_emul
// PURPOSE
// - ASE-only Ethernet partner for one HSSI channel. It sinks AFU TX AXI-S frames into a store-and-forward FIFO and replays them on the RX stream.
// - Replaces the constant tie-offs (rx=0, tready=1) in the afu_main emulation wrapper. One instance is placed per channel, on that channel's HSSI clock.
// - Whole-frame buffering is required because RX has no tready: a frame, once started, must stream without bubbles.
// PARAMETERS
// - DATA_W, 64: tdata width in bits. tkeep width is DATA_W/8.
// - USER_W, 1: tuser width, carried verbatim.
// - DEPTH, 64: FIFO beats. Power of 2, at least 4.
// - IPG_CYCLES, 2: idle cycles forced on RX between frames. 0 is legal.
// PORTS
// - clk           in   1         channel clock
// - softReset     in   1         synchronous reset, active-high
// - tx_tvalid     in   1         AFU TX beat valid
// - tx_tready     out  1         loopback can accept a beat
// - tx_tdata      in   DATA_W    TX data
// - tx_tkeep      in   DATA_W/8  TX byte enables
// - tx_tlast      in   1         end of frame
// - tx_tuser      in   USER_W    TX sideband
// - rx_tvalid     out  1         RX beat valid; there is no ready
// - rx_tdata      out  DATA_W    RX data
// - rx_tkeep      out  DATA_W/8  RX byte enables
// - rx_tlast      out  1         RX end of frame
// - rx_tuser      out  USER_W    RX sideband
// - frames_looped out  32        frames fully sent on RX; wraps
// - frames_dropped out 32        oversize frames discarded; wraps
// BEHAVIOUR
// - Reset: every output is 0 except tx_tready. Pointers, counters and both FSMs are cleared. tx_tready is 1 from the first cycle after reset.
//   Reset mid-frame abandons both directions immediately. There is no partial flush: rx_tvalid is 0 in the cycle after reset is sampled.
// - Write FSM, states WR_ACCEPT and WR_DROP:
//   - WR_ACCEPT: tx_tready = !full. A beat is accepted when tx_tvalid && tx_tready.
//     It writes {data,keep,last,user} at wr_ptr, and wr_ptr increments modulo DEPTH.
//   - On an accepted tlast beat: commit_ptr <= wr_ptr+1 and complete_cnt increments. The frame becomes visible to the reader on the next cycle.
//   - Oversize: FIFO full, complete_cnt==0, and the in-progress frame has no tlast. Then wr_ptr <= commit_ptr (rewind), go to WR_DROP, and frames_dropped increments.
//   - WR_DROP: tx_tready=1 and beats are discarded. The tlast beat returns the FSM to WR_ACCEPT.
//   - When full while complete frames are held, this is ordinary backpressure: tx_tready=0 until the reader frees space.
// - Read FSM, states RD_IDLE, RD_SEND and RD_GAP:
//   - RD_IDLE: if complete_cnt>0, go to RD_SEND. The first beat is registered out on the next cycle.
//   - RD_SEND: one beat per cycle, rx_tvalid=1 continuously until the beat with tlast. That beat decrements complete_cnt and increments frames_looped.
//     Then go to RD_GAP, or go straight to RD_IDLE/RD_SEND when IPG_CYCLES==0.
//   - RD_GAP: rx_tvalid=0 for exactly IPG_CYCLES cycles, then go to RD_IDLE. If a frame is ready, the next frame starts on the following cycle.
// - Latency: tlast accepted at cycle N gives first RX beat at N+2, provided the reader is idle.
// - Simultaneous events: commit and read-complete in the same cycle leave complete_cnt unchanged. Free-space accounting uses the pointers as they stand after both updates.
// - full = (wr_ptr - rd_ptr) == DEPTH. Pointers are $clog2(DEPTH)+1 bits wide.
// - Counters wrap at 2^32 without saturating.
// - The first RX beat of a frame depends only on committed data, so RX never underruns mid-frame.
// TESTING
// - Single frame of 3 beats, tkeep last=8'h0F, IPG 2:
//   RX shows 3 contiguous beats, identical data/keep/user, first beat 2 cycles after TX tlast; frames_looped=1.
// - Back-to-back 1-beat frames x10 with tx_tvalid held high:
//   exactly 2 idle cycles between RX beats; frames_looped=10; no beat loss.
// - DEPTH=8, 20-beat frame followed by a 2-beat frame:
//   frames_dropped=1, no RX beats from the first frame; the second frame is looped intact.
// - Fill with 4 complete 2-beat frames (DEPTH=8), then offer a 5th:
//   tx_tready=0 until the reader frees space; all 5 frames come out in order.
// - Assert softReset mid-RX frame:
//   rx_tvalid=0 the next cycle; counters=0; a fresh frame after reset loops correctly.
// - 2^32 wrap: force frames_looped to 32'hFFFF_FFFF and loop one frame: counter reads 0.

Source files
------------

// File: rtl/ase_hssi_loopback_emul.sv
// Simulation-only Ethernet partner for one HSSI channel: TX frames are buffered
// whole in a store-and-forward FIFO and replayed on RX with a fixed inter-packet gap.
module ase_hssi_loopback_emul #(
    parameter int DATA_W     = 64,
    parameter int USER_W     = 1,
    parameter int DEPTH      = 64,
    parameter int IPG_CYCLES = 2
) (
    input  logic                clk,
    input  logic                softReset,
    input  logic                tx_tvalid,
    output logic                tx_tready,
    input  logic [DATA_W-1:0]   tx_tdata,
    input  logic [DATA_W/8-1:0] tx_tkeep,
    input  logic                tx_tlast,
    input  logic [USER_W-1:0]   tx_tuser,
    output logic                rx_tvalid,
    output logic [DATA_W-1:0]   rx_tdata,
    output logic [DATA_W/8-1:0] rx_tkeep,
    output logic                rx_tlast,
    output logic [USER_W-1:0]   rx_tuser,
    output logic [31:0]         frames_looped,
    output logic [31:0]         frames_dropped
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1 + USER_W;
    localparam int GAP_W   = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : '0;

    typedef enum logic {WR_ACCEPT, WR_DROP} wrState_t;
    typedef enum logic [1:0] {RD_IDLE, RD_SEND, RD_GAP} rdState_t;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wrPtr, rdPtr, commitPtr, completeCnt;
    logic [PW-1:0]      wrPtrNxt, rdPtrNxt;
    wrState_t           wrState, wrStateNxt;
    rdState_t           rdState;
    logic [GAP_W-1:0]   gapCnt;
    logic               full, wrAccept, commit, oversize, rdLoad, rdLast;
    logic [ENTRY_W-1:0] rdEntry;

    assign rdEntry  = mem[rdPtr[AW-1:0]];
    assign full     = (wrPtr - rdPtr) == PW'(DEPTH);
    assign wrAccept = (wrState == WR_ACCEPT) && tx_tvalid && tx_tready;
    assign commit   = wrAccept && tx_tlast;
    // A full FIFO holding no complete frame can only be one frame too big to ever fit.
    assign oversize = (wrState == WR_ACCEPT) && full && (completeCnt == '0);
    assign rdLast   = rdLoad && rdEntry[USER_W];

    always_comb begin
        rdLoad = 1'b0;
        unique case (rdState)
            RD_IDLE: rdLoad = completeCnt != '0;
            RD_SEND: rdLoad = !rx_tlast || ((IPG_CYCLES == 0) && (completeCnt != '0));
            RD_GAP:  rdLoad = (gapCnt == '0) && (completeCnt != '0);
            default: rdLoad = 1'b0;
        endcase
    end

    always_comb begin
        wrPtrNxt   = wrPtr;
        wrStateNxt = wrState;
        if (oversize) begin
            wrPtrNxt   = commitPtr;
            wrStateNxt = WR_DROP;
        end else if (wrAccept) begin
            wrPtrNxt = wrPtr + PW'(1);
        end else if ((wrState == WR_DROP) && tx_tvalid && tx_tready && tx_tlast) begin
            wrStateNxt = WR_ACCEPT;
        end
        rdPtrNxt = rdPtr + PW'(rdLoad);
    end

    always_ff @(posedge clk) begin
        if (wrAccept)
            mem[wrPtr[AW-1:0]] <= {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
    end

    // Write side: tx_tready is registered from the post-update pointers.
    always_ff @(posedge clk) begin
        if (softReset) begin
            wrState        <= WR_ACCEPT;
            wrPtr          <= '0;
            commitPtr      <= '0;
            tx_tready      <= 1'b1;
            frames_dropped <= '0;
        end else begin
            wrState   <= wrStateNxt;
            wrPtr     <= wrPtrNxt;
            tx_tready <= (wrStateNxt == WR_DROP) || ((wrPtrNxt - rdPtrNxt) != PW'(DEPTH));
            if (commit)
                commitPtr <= wrPtr + PW'(1);
            if (oversize)
                frames_dropped <= frames_dropped + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (softReset)
            completeCnt <= '0;
        else
            completeCnt <= completeCnt + PW'(commit) - PW'(rdLast);
    end

    // Read side: a frame is only started once committed, so it streams without bubbles.
    always_ff @(posedge clk) begin
        if (softReset) begin
            rdState       <= RD_IDLE;
            rdPtr         <= '0;
            gapCnt        <= '0;
            rx_tvalid     <= 1'b0;
            rx_tdata      <= '0;
            rx_tkeep      <= '0;
            rx_tlast      <= 1'b0;
            rx_tuser      <= '0;
            frames_looped <= '0;
        end else begin
            rdPtr <= rdPtrNxt;
            if (rdLast)
                frames_looped <= frames_looped + 32'd1;
            if (rdLoad) begin
                {rx_tdata, rx_tkeep, rx_tlast, rx_tuser} <= rdEntry;
                rx_tvalid <= 1'b1;
                rdState   <= RD_SEND;
            end else begin
                rx_tvalid <= 1'b0;
                unique case (rdState)
                    RD_SEND: begin
                        rdState <= (IPG_CYCLES > 0) ? RD_GAP : RD_IDLE;
                        gapCnt  <= GAP_INIT;
                    end
                    RD_GAP: begin
                        if (gapCnt == '0)
                            rdState <= RD_IDLE;
                        else
                            gapCnt <= gapCnt - GAP_W'(1);
                    end
                    default: rdState <= RD_IDLE;
                endcase
            end
        end
    end
endmodule
